cdc_rx_scheduler: RTL and testbench
===================================

# cdc_rx_scheduler

Destination-domain controller for a bank of multi-bit clock-domain-crossing channels built on double-flop synchronizers. Each channel uses a toggle req/ack handshake: the sender holds its data and flips a request toggle, and the toggle arrives here already synchronized. This block round-robins among pending channels, waits a settle interval, captures the data and presents it on a valid/ready stream. It then returns an ack toggle to the winning channel.

## Interface
- NUM_CH, 4: number of channels, 2..16.
- DATA_W, 4: data width per channel.
- SETTLE, 2: cycles to wait after grant before capture, ≥1.
- clk_b  input  1  destination clock.
- rst_b  input  1  asynchronous active-low reset.
- req_tgl_sync  input  NUM_CH  per-channel request toggles, already double-flop synchronized.
- data_sync  input  NUM_CH*DATA_W  per-channel data; channel i is bits [i*DATA_W +: DATA_W].
- ack_tgl  output  NUM_CH  per-channel ack toggles, registered, returned to the senders.
- out_valid  output  1  captured word available.
- out_ready  input  1  consumer accepts the word.
- out_data  output  DATA_W  captured word.
- out_ch  output  max(1,$clog2(NUM_CH))  channel index of out_data.
- err  output  1  sticky stability error; see Configuration.

## Operation
- pending[i] = req_tgl_sync[i] XOR ack_tgl[i].
- Round-robin pointer ptr starts at 0. The arbiter grants the first pending channel found searching ptr, ptr+1, … with wrap at NUM_CH-1 → 0.
- FSM states:
  - IDLE: if any pending, latch grant and set cnt=0, then go to SETTLE. Otherwise stay in IDLE.
  - SETTLE: cnt increments each cycle. When cnt==SETTLE-1, out_data ← data slice of grant and out_ch ← grant, then go to VALID.
  - VALID: out_valid=1. When out_ready=1, toggle ack_tgl[grant], set ptr ← grant+1 (wrap to 0 past NUM_CH-1), and go to IDLE.
- The grant stays locked from IDLE exit until the VALID handshake. New requests arriving meanwhile only wait; there is no preemption.
- Senders must not toggle the request or change data until they see the ack. A granted transfer always completes, even if its pending drops (protocol violation).
- One transfer is in flight at a time. ack_tgl toggles on exactly one bit per accepted transfer.

## Timing
- Reset values: ack_tgl=0, out_valid=0, out_data=0, out_ch=0, err=0, ptr=0, state=IDLE, cnt=0.
- Latency: if pending is first high in cycle 0 (IDLE), out_valid rises in cycle SETTLE+1.
- out_data and out_ch are stable while out_valid=1.
- ack_tgl flips on the clock edge that completes out_valid&&out_ready. out_valid drops in the same cycle.
- Minimum spacing is SETTLE+2 cycles per transfer with out_ready held at 1. This includes one IDLE cycle between transfers.
- Pending is re-evaluated in IDLE only. A channel whose ack has just toggled is not pending in that IDLE cycle.
- Reset asserted mid-transfer aborts immediately to reset values. Senders must be reset in the same event.

## Configuration
- CDC_RX_STABLE_CHK_EN defined:
  - In SETTLE, the granted data slice is compared with its value one cycle earlier.
  - On a mismatch, cnt restarts at 0 and err is set. err is sticky until reset.
  - In VALID, pending[grant]==0 also sets err.
- CDC_RX_STABLE_CHK_EN undefined: no comparison is made, err is tied to 0, and SETTLE timing is fixed.

## Test plan
- Single request: reset, then toggle req_tgl_sync[2] with data 0xA and out_ready=1, SETTLE=2 → out_valid in cycle 3, out_data=0xA, out_ch=2, then ack_tgl[2] flips to 1 and pending clears.
- Round robin: all four channels pending with data 0x1..0x4 and ptr=0 → outputs in order ch0, ch1, ch2, ch3 with spacing SETTLE+2. Then re-toggle ch0 and ch3 → ch0 is served before ch3 (ptr wraps to 0).
- Backpressure: out_ready=0 for 10 cycles while in VALID → out_valid, out_data and out_ch are held, ack_tgl is unchanged. Raising out_ready → exactly one ack flip.
- Reset mid-transfer: drop rst_b while in SETTLE for ch1 → all outputs return to 0 in the same cycle. After release with req_tgl_sync=0 → no output.
- Stability check (macro defined): change ch1 data from 0x5 to 0x6 during SETTLE → err=1, the settle counter restarts, and out_data=0x6. With the macro undefined, err stays 0.

Source files
------------

// File: rtl/cdc_rx_scheduler.sv
// cdc_rx_scheduler: round-robin capture of toggle-handshake CDC channels onto a valid/ready stream.
// Define CDC_RX_STABLE_CHK_EN to add settle-window data stability checking and the sticky err flag.
module cdc_rx_scheduler #(
  parameter int  NUM_CH = 4,
  parameter int  DATA_W = 4,
  parameter int  SETTLE = 2,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_b,
  input  logic                     rst_b,
  input  logic [NUM_CH-1:0]        req_tgl_sync,
  input  logic [NUM_CH*DATA_W-1:0] data_sync,
  output logic [NUM_CH-1:0]        ack_tgl,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     err
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int IDX_W = CH_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] IDX_N    = IDX_W'(NUM_CH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_VALID
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   gnt_q, gnt_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CH_W-1:0]   ch_q, ch_d;

  logic [NUM_CH-1:0] pending;
  logic [IDX_W-1:0]  idx;
  logic [CH_W-1:0]   sel;
  logic              sel_any;
  logic [DATA_W-1:0] gnt_data;
  logic              unstable;

  assign pending  = req_tgl_sync ^ ack_q;
  assign gnt_data = data_sync[gnt_q*DATA_W +: DATA_W];

  // Walk from the highest offset down so the nearest pending channel after ptr wins.
  always_comb begin
    sel     = ptr_q;
    sel_any = 1'b0;
    idx     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = IDX_W'(ptr_q) + IDX_W'(i);
      if (idx >= IDX_N) begin
        idx = idx - IDX_N;
      end
      if (pending[idx[CH_W-1:0]]) begin
        sel     = idx[CH_W-1:0];
        sel_any = 1'b1;
      end
    end
  end

`ifdef CDC_RX_STABLE_CHK_EN
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] sel_data;

  assign sel_data = data_sync[sel*DATA_W +: DATA_W];
  assign unstable = (state_q == S_SETTLE)
                 && (gnt_data != prev_q);

  always_comb begin
    prev_d = prev_q;
    err_d  = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (sel_any) begin
          prev_d = sel_data;
        end
      end
      S_SETTLE: begin
        prev_d = gnt_data;
        if (unstable) begin
          err_d = 1'b1;
        end
      end
      S_VALID: begin
        if (!pending[gnt_q]) begin
          err_d = 1'b1;
        end
      end
      default: begin
        prev_d = prev_q;
      end
    endcase
  end

  always_ff @(posedge clk_b or negedge rst_b) begin
    if (!rst_b) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign unstable = 1'b0;
  assign err      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    data_d  = data_q;
    ch_d    = ch_q;
    unique case (state_q)
      S_IDLE: begin
        if (sel_any) begin
          gnt_d   = sel;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (unstable) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = gnt_data;
          ch_d    = gnt_q;
          state_d = S_VALID;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_VALID: begin
        if (out_ready) begin
          ack_d[gnt_q] = ~ack_q[gnt_q];
          ptr_d = (gnt_q == CH_LAST) ? '0
                : gnt_q + CH_W'(1);
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_b or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
    end
  end

  assign ack_tgl   = ack_q;
  assign out_valid = (state_q == S_VALID);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule

// File: tb/tb_cdc_rx_scheduler.sv
// tb_cdc_rx_scheduler: directed scenarios plus randomized senders
// checked every cycle against a transfer-level timing model.
module tb_cdc_rx_scheduler;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 4;
  localparam int SETTLE = 2;
  localparam int CH_W   = 2;
`ifdef CDC_RX_STABLE_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic                     clk_b = 1'b0;
  logic                     rst_b;
  logic [NUM_CH-1:0]        req_tgl_sync;
  logic [NUM_CH*DATA_W-1:0] data_sync;
  logic [NUM_CH-1:0]        ack_tgl;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_b = ~clk_b;

  cdc_rx_scheduler #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
    .SETTLE(SETTLE)
  ) dut (
    .clk_b       (clk_b),
    .rst_b       (rst_b),
    .req_tgl_sync(req_tgl_sync),
    .data_sync   (data_sync),
    .ack_tgl     (ack_tgl),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ch      (out_ch),
    .err         (err)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] slice(input int c);
    return data_sync[c*DATA_W +: DATA_W];
  endfunction

  // Transfer-level model: a grant taken in cycle tg_m is visible from
  // cycle tg_m+SETTLE+1 until the cycle the consumer accepts it.
  int                cyc    = 0;
  bit                busy_m = 1'b0;
  int                win_m  = 0;
  int                ptr_m  = 0;
  int                tg_m   = 0;
  logic [NUM_CH-1:0] ack_m  = '0;
  logic [DATA_W-1:0] cap_m  = '0;
  logic [DATA_W-1:0] prev_m = '0;
  bit                err_m  = 1'b0;

  always @(negedge clk_b) begin
    logic [NUM_CH-1:0] pend;
    bit                vld;
    int                j;
    cyc++;
    if (!rst_b) begin
      busy_m = 1'b0;
      ptr_m  = 0;
      ack_m  = '0;
      err_m  = 1'b0;
      chk("rst valid", 32'(out_valid), 0);
      chk("rst ack", 32'(ack_tgl), 0);
      chk("rst data", 32'(out_data), 0);
      chk("rst ch", 32'(out_ch), 0);
      chk("rst err", 32'(err), 0);
    end else begin
      vld = busy_m && (cyc > tg_m + SETTLE);
      chk("valid", 32'(out_valid), 32'(vld));
      chk("ack", 32'(ack_tgl), 32'(ack_m));
      chk("err", 32'(err), 32'(err_m));
      if (vld) begin
        chk("data", 32'(out_data), 32'(cap_m));
        chk("ch", 32'(out_ch), 32'(win_m));
        if (CHK_EN && (req_tgl_sync[win_m] == ack_m[win_m]))
          err_m = 1'b1;
        if (out_ready) begin
          ack_m[win_m] = ~ack_m[win_m];
          ptr_m  = (win_m + 1) % NUM_CH;
          busy_m = 1'b0;
        end
      end else if (busy_m) begin
        if (CHK_EN && (slice(win_m) != prev_m)) begin
          tg_m  = cyc;
          err_m = 1'b1;
        end else if (cyc == tg_m + SETTLE) begin
          cap_m = slice(win_m);
        end
        prev_m = slice(win_m);
      end else begin
        pend = req_tgl_sync ^ ack_m;
        for (int k = 0; k < NUM_CH; k++) begin
          j = (ptr_m + k) % NUM_CH;
          if (!busy_m && pend[j]) begin
            busy_m = 1'b1;
            win_m  = j;
            tg_m   = cyc;
            prev_m = slice(j);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_b);
    #1;
  endtask

  task automatic do_reset();
    rst_b        = 1'b0;
    req_tgl_sync = '0;
    data_sync    = '0;
    out_ready    = 1'b0;
    tick(2);
    rst_b = 1'b1;
  endtask

  initial begin
    int n;

    // single request on ch2
    do_reset();
    chk("t1 reset ack", 32'(ack_tgl), 0);
    chk("t1 reset valid", 32'(out_valid), 0);
    out_ready = 1'b1;
    data_sync[2*DATA_W +: DATA_W] = 4'hA;
    req_tgl_sync[2] = 1'b1;
    tick(SETTLE);
    chk("t1 early valid", 32'(out_valid), 0);
    tick(1);
    chk("t1 valid", 32'(out_valid), 1);
    chk("t1 data", 32'(out_data), 'hA);
    chk("t1 ch", 32'(out_ch), 2);
    chk("t1 ack before", 32'(ack_tgl), 0);
    tick(1);
    chk("t1 ack after", 32'(ack_tgl), 'h4);
    chk("t1 valid drop", 32'(out_valid), 0);
    chk("t1 pending", 32'(req_tgl_sync ^ ack_tgl), 0);

    // round robin over all four, then wrap
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < NUM_CH; c++)
      data_sync[c*DATA_W +: DATA_W] = DATA_W'(c + 1);
    req_tgl_sync = 4'hF;
    for (int k = 0; k < NUM_CH; k++) begin
      tick(k == 0 ? SETTLE + 1 : SETTLE + 2);
      chk("t2 valid", 32'(out_valid), 1);
      chk("t2 ch", 32'(out_ch), 32'(k));
      chk("t2 data", 32'(out_data), 32'(k + 1));
    end
    tick(1);
    chk("t2 ack all", 32'(ack_tgl), 'hF);
    data_sync[0 +: DATA_W]        = 4'h7;
    data_sync[3*DATA_W +: DATA_W] = 4'h9;
    req_tgl_sync = 4'b0110;
    tick(SETTLE + 1);
    chk("t2 wrap ch0", 32'(out_ch), 0);
    chk("t2 wrap d0", 32'(out_data), 'h7);
    tick(SETTLE + 2);
    chk("t2 wrap ch3", 32'(out_ch), 3);
    chk("t2 wrap d3", 32'(out_data), 'h9);
    tick(1);
    chk("t2 wrap ack", 32'(ack_tgl), 'h6);

    // backpressure on ch1
    out_ready = 1'b0;
    data_sync[1*DATA_W +: DATA_W] = 4'h5;
    req_tgl_sync[1] = ~req_tgl_sync[1];
    tick(SETTLE + 1);
    for (int k = 0; k < 10; k++) begin
      chk("t3 hold valid", 32'(out_valid), 1);
      chk("t3 hold data", 32'(out_data), 'h5);
      chk("t3 hold ch", 32'(out_ch), 1);
      chk("t3 hold ack", 32'(ack_tgl), 'h6);
      tick(1);
    end
    out_ready = 1'b1;
    tick(1);
    chk("t3 one flip", 32'(ack_tgl), 'h4);
    chk("t3 valid drop", 32'(out_valid), 0);

    // reset while settling on ch1
    data_sync[1*DATA_W +: DATA_W] = 4'h3;
    req_tgl_sync[1] = ~req_tgl_sync[1];
    tick(1);
    #1;
    rst_b        = 1'b0;
    req_tgl_sync = '0;
    data_sync    = '0;
    #1;
    chk("t4 ack", 32'(ack_tgl), 0);
    chk("t4 valid", 32'(out_valid), 0);
    chk("t4 data", 32'(out_data), 0);
    chk("t4 ch", 32'(out_ch), 0);
    chk("t4 err", 32'(err), 0);
    tick(2);
    rst_b = 1'b1;
    tick(10);
    chk("t4 quiet valid", 32'(out_valid), 0);
    chk("t4 quiet ack", 32'(ack_tgl), 0);

    // data moves during settle
    do_reset();
    out_ready = 1'b1;
    data_sync[1*DATA_W +: DATA_W] = 4'h5;
    req_tgl_sync[1] = 1'b1;
    tick(1);
    data_sync[1*DATA_W +: DATA_W] = 4'h6;
    n = 0;
    while (!out_valid && n < 20) begin
      tick(1);
      n++;
    end
    chk("t5 latency", 32'(n), 32'(SETTLE + int'(CHK_EN)));
    chk("t5 data", 32'(out_data), 'h6);
    chk("t5 ch", 32'(out_ch), 1);
    chk("t5 err", 32'(err), 32'(CHK_EN));
    tick(3);
    chk("t5 err sticky", 32'(err), 32'(CHK_EN));

    // randomized senders and consumer
    do_reset();
    for (int s = 0; s < 3000; s++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM_CH; i++) begin
        if (req_tgl_sync[i] == ack_tgl[i]
            && $urandom_range(0, 2) == 0) begin
          data_sync[i*DATA_W +: DATA_W] = DATA_W'($urandom);
          req_tgl_sync[i] = ~req_tgl_sync[i];
        end
      end
      tick(1);
    end
    out_ready = 1'b1;
    tick(NUM_CH * (SETTLE + 2) + 4);
    chk("drain", 32'(ack_tgl), 32'(req_tgl_sync));
    chk("drain valid", 32'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
